// File: rtl/priority_stimulus_encoder.sv
// Priority stimulus encoder: accepts requested detector output codes,
// queues the matching detector input vectors in a small FIFO and plays
// each one out for HOLD_CYCLES cycles followed by GAP_CYCLES idle cycles.
module priority_stimulus_encoder #(
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 2,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [2:0]               in_code,
    output logic                     in_ready,
    output logic                     A,
    output logic                     B,
    output logic                     C,
    output logic                     vec_valid,
    output logic                     done,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // Map a requested code {Z,Y,X} to {legal, C, B, A}; the vector is the
    // inverse of the detector truth table, multi-hot codes are illegal.
    function automatic logic [3:0] map_code(input logic [2:0] code);
        logic [3:0] res;
        case (code)
            3'b000:  res = {1'b1, 3'b000};
            3'b001:  res = {1'b1, 3'b001};
            3'b010:  res = {1'b1, 3'b100};
            3'b100:  res = {1'b1, 3'b010};
            default: res = {1'b0, 3'b000};
        endcase
        return res;
    endfunction

    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q,  level_d;
    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [2:0]    vec_q,    vec_d;
    logic          vld_q,    vld_d;
    logic          done_q,   done_d;
    logic          err_q;
    logic          busy_q;

    logic [3:0]    map_s;
    logic          accept_s;
    logic          push_s;
    logic          pop_s;

    assign map_s    = map_code(in_code);
    assign in_ready = (level_q < LW'(DEPTH));
    assign accept_s = in_valid & in_ready;
    assign push_s   = accept_s & map_s[3];
    assign pop_s    = (state_q == ST_IDLE) && (level_q != {LW{1'b0}});

    assign A         = vec_q[0];
    assign B         = vec_q[1];
    assign C         = vec_q[2];
    assign vec_valid = vld_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign level     = level_q;

    // Occupancy next value: simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Playback sequencer: IDLE pops, DRIVE holds the vector, GAP forces zeros.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_DRIVE;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                    vec_d   = mem_q[rd_ptr_q];
                    vld_d   = 1'b1;
                end else begin
                    vec_d   = 3'b000;
                    vld_d   = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == {CW{1'b0}}) begin
                    done_d = 1'b1;
                    vec_d  = 3'b000;
                    vld_d  = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = CW'(GAP_CYCLES - 1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_GAP: begin
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                vec_d   = 3'b000;
                vld_d   = 1'b0;
            end
        endcase
    end

    // FIFO storage and pointers; entries hold mapped vectors, not codes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= map_s[2:0];
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Sequencer state and registered outputs toward the detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            vec_q   <= 3'b000;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            err_q   <= accept_s & ~map_s[3];
            busy_q  <= (state_d != ST_IDLE) || (level_d != {LW{1'b0}});
        end
    end

endmodule

// File: tb/tb_priority_stimulus_encoder.sv
// Bench for priority_stimulus_encoder: two configurations (default and
// HOLD=1/GAP=0) share one stimulus stream; each is compared every cycle
// against a schedule-based reference model, plus directed literal checks.
module tb_priority_stimulus_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_code;

    logic       rdy_s  [2];
    logic       a_s    [2];
    logic       b_s    [2];
    logic       c_s    [2];
    logic       vv_s   [2];
    logic       done_s [2];
    logic       err_s  [2];
    logic       busy_s [2];
    logic [2:0] lvl_s  [2];

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         s;
        logic [2:0] v;
    } job_t;

    task automatic chk(input string name, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit ref_legal(input logic [2:0] code);
        return $countones(code) <= 1;
    endfunction

    // X drives A, Y drives C, Z drives B.
    function automatic logic [2:0] ref_vec(input logic [2:0] code);
        return {code[1], code[2], code[0]};
    endfunction

    function automatic int vec_of(input int i);
        return int'({c_s[i], b_s[i], a_s[i]});
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g
        localparam int H = (gi == 0) ? 8 : 1;
        localparam int G = (gi == 0) ? 2 : 0;
        localparam int D = 4;

        priority_stimulus_encoder #(
            .HOLD_CYCLES(H), .GAP_CYCLES(G), .DEPTH(D)
        ) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_code(in_code),
            .in_ready(rdy_s[gi]), .A(a_s[gi]), .B(b_s[gi]), .C(c_s[gi]),
            .vec_valid(vv_s[gi]), .done(done_s[gi]), .err(err_s[gi]),
            .busy(busy_s[gi]), .level(lvl_s[gi])
        );

        // Each accepted legal request gets a start edge s; it is driven after
        // edges s..s+H-1, done after s+H, and the block is busy until s+H+G.
        job_t jobs[$];
        int   t;
        int   nf;
        int   err_e;

        function automatic int lvl_at(input int tt);
            int n = 0;
            foreach (jobs[k]) if (jobs[k].s > tt) n++;
            return n;
        endfunction

        always @(posedge clk) begin
            int         el;
            int         st;
            logic [2:0] ev;
            logic       evld, edn, ebz;
            string      p;
            p = $sformatf("cfg%0d", gi);
            if (!rst_n) begin
                jobs.delete();
                t = 0; nf = 0; err_e = -10;
                #1;
                chk({p, " rst vec"},   vec_of(gi), 0);
                chk({p, " rst valid"}, int'(vv_s[gi]), 0);
                chk({p, " rst done"},  int'(done_s[gi]), 0);
                chk({p, " rst level"}, int'(lvl_s[gi]), 0);
                chk({p, " rst ready"}, int'(rdy_s[gi]), 1);
            end else begin
                t++;
                if (in_valid && lvl_at(t - 1) < D) begin
                    if (ref_legal(in_code)) begin
                        st = (t + 1 > nf) ? t + 1 : nf;
                        jobs.push_back('{s: st, v: ref_vec(in_code)});
                        nf = st + H + G + 1;
                    end else begin
                        err_e = t;
                    end
                end
                #1;
                el = lvl_at(t);
                ev = 3'b000; evld = 1'b0; edn = 1'b0; ebz = (el > 0);
                foreach (jobs[k]) begin
                    if (t >= jobs[k].s && t <= jobs[k].s + H - 1) begin
                        evld = 1'b1; ev = jobs[k].v;
                    end
                    if (t == jobs[k].s + H) edn = 1'b1;
                    if (t >= jobs[k].s && t <= jobs[k].s + H + G - 1) ebz = 1'b1;
                end
                chk({p, " vec"},   vec_of(gi), int'(ev));
                chk({p, " valid"}, int'(vv_s[gi]), int'(evld));
                chk({p, " done"},  int'(done_s[gi]), int'(edn));
                chk({p, " err"},   int'(err_s[gi]), (err_e == t) ? 1 : 0);
                chk({p, " busy"},  int'(busy_s[gi]), int'(ebz));
                chk({p, " level"}, int'(lvl_s[gi]), el);
                chk({p, " ready"}, int'(rdy_s[gi]), (el < D) ? 1 : 0);
                while (jobs.size() > 0 && jobs[0].s + H + G + 2 < t) void'(jobs.pop_front());
            end
        end
    end

    // Monitor on the default configuration: vector order and start cycles.
    logic       vv_prev = 1'b0;
    int         cyc     = 0;
    int         ndone   = 0;
    logic [2:0] obs[$];
    int         starts[$];
    always @(posedge clk) begin
        #1;
        if (vv_s[0] && !vv_prev) begin
            obs.push_back({c_s[0], b_s[0], a_s[0]});
            starts.push_back(cyc);
        end
        if (done_s[0]) ndone++;
        vv_prev = vv_s[0];
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy_s[0] || busy_s[1]) && n < 300) begin
            step();
            n++;
        end
        chk("idle timeout", n < 300 ? 1 : 0, 1);
        step();
    endtask

    task automatic push(input logic [2:0] code);
        in_valid = 1'b1;
        in_code  = code;
        step();
        in_valid = 1'b0;
    endtask

    logic [2:0] seq[6] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b001, 3'b010};

    initial begin
        int maxl;
        int guard;
        bit seen_full;
        rst_n = 1'b0; in_valid = 1'b0; in_code = 3'b000;
        repeat (3) step();
        chk("reset busy", int'(busy_s[0]), 0);
        chk("reset ready", int'(rdy_s[1]), 1);
        rst_n = 1'b1;

        // Single request 001: driven edges 1..8, done at 9, idle from 11.
        push(3'b001);
        for (int n = 1; n <= 8; n++) begin
            step();
            chk("single vec", vec_of(0), 1);
            chk("single valid", int'(vv_s[0]), 1);
        end
        step();
        chk("single done", int'(done_s[0]), 1);
        chk("single end valid", int'(vv_s[0]), 0);
        step();
        chk("single gap vec", vec_of(0), 0);
        chk("single gap busy", int'(busy_s[0]), 1);
        step();
        chk("single idle busy", int'(busy_s[0]), 0);
        wait_idle();

        // Illegal 111 then legal 010.
        push(3'b111);
        chk("illegal err", int'(err_s[0]), 1);
        chk("illegal level", int'(lvl_s[0]), 0);
        step();
        chk("illegal no drive", int'(vv_s[0]), 0);
        chk("illegal err gone", int'(err_s[0]), 0);
        push(3'b010);
        step();
        chk("after illegal vec", vec_of(0), 4);
        chk("after illegal valid", int'(vv_s[0]), 1);
        wait_idle();

        // Back-to-back 100, 010, 000.
        obs.delete(); starts.delete(); ndone = 0;
        push(3'b100); push(3'b010); push(3'b000);
        wait_idle();
        chk("b2b count", obs.size(), 3);
        if (obs.size() == 3) begin
            chk("b2b v0", int'(obs[0]), 2);
            chk("b2b v1", int'(obs[1]), 4);
            chk("b2b v2", int'(obs[2]), 0);
            chk("b2b period", starts[1] - starts[0], 11);
            chk("b2b period2", starts[2] - starts[1], 11);
        end
        chk("b2b dones", ndone, 3);

        // Overflow: six requests, held off while the FIFO is full.
        obs.delete(); maxl = 0; seen_full = 1'b0;
        for (int j = 0; j < 6; j++) begin
            in_valid = 1'b1;
            in_code  = seq[j];
            guard = 0;
            while (!rdy_s[0] && guard < 100) begin
                if (!seen_full) begin
                    chk("full level", int'(lvl_s[0]), 4);
                    seen_full = 1'b1;
                end
                step();
                guard++;
            end
            chk("holdoff timeout", guard < 100 ? 1 : 0, 1);
            step();
            if (int'(lvl_s[0]) > maxl) maxl = int'(lvl_s[0]);
        end
        in_valid = 1'b0;
        wait_idle();
        chk("overflow max level", maxl, 4);
        chk("overflow saw full", int'(seen_full), 1);
        chk("overflow count", obs.size(), 6);
        for (int j = 0; j < 6 && j < obs.size(); j++) begin
            chk("overflow order", int'(obs[j]), int'(ref_vec(seq[j])));
        end

        // HOLD=1, GAP=0 configuration: DRIVE, IDLE, DRIVE.
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        in_valid = 1'b1; in_code = 3'b001; step();
        in_code = 3'b010; step();
        in_valid = 1'b0;
        chk("h1 drive1 valid", int'(vv_s[1]), 1);
        chk("h1 drive1 vec", vec_of(1), 1);
        step();
        chk("h1 idle valid", int'(vv_s[1]), 0);
        chk("h1 done1", int'(done_s[1]), 1);
        step();
        chk("h1 drive2 valid", int'(vv_s[1]), 1);
        chk("h1 drive2 vec", vec_of(1), 4);
        chk("h1 no done", int'(done_s[1]), 0);
        step();
        chk("h1 done2", int'(done_s[1]), 1);
        wait_idle();

        // Reset in the 4th DRIVE cycle with two requests queued.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        push(3'b001); push(3'b010); push(3'b100);
        step(); step();
        chk("mid drive valid", int'(vv_s[0]), 1);
        chk("mid queued", int'(lvl_s[0]), 2);
        rst_n = 1'b0;
        #1;
        chk("abort valid", int'(vv_s[0]), 0);
        chk("abort vec", vec_of(0), 0);
        chk("abort level", int'(lvl_s[0]), 0);
        chk("abort busy", int'(busy_s[0]), 0);
        chk("abort ready", int'(rdy_s[0]), 1);
        step();
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            step();
            chk("post abort done", int'(done_s[0]), 0);
            chk("post abort valid", int'(vv_s[0]), 0);
        end

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                in_valid = 1'b0;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end else begin
                in_valid = ($urandom_range(0, 2) != 0);
                if ($urandom_range(0, 4) == 0) begin
                    in_code = 3'($urandom_range(0, 7));
                end else begin
                    case ($urandom_range(0, 3))
                        0:       in_code = 3'b000;
                        1:       in_code = 3'b001;
                        2:       in_code = 3'b010;
                        default: in_code = 3'b100;
                    endcase
                end
                step();
            end
        end
        in_valid = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
